// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   ALU_MULT / ALU_DIV : ALU control codes, shared with the ALU control decoder
//   state_t            : unit FSM states
//   cnt_width()        : iteration counter width for a given operand width
package muldiv_pkg;

    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negate.
// Used both to take operand magnitudes at capture and to restore result
// signs in FIX.
//   val : input value
//   neg : 1 = return -val, 0 = pass val through
//   res : result
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS32 mult/div unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per RUN cycle, sign correction in FIX.
//   clk, reset         : clock, synchronous active-high reset
//   start, alu_ctrl    : request + operation (0101 mult, 1011 div)
//   op_signed          : 1 = signed mult/div, 0 = multu/divu
//   src_a, src_b       : multiplicand/dividend, multiplier/divisor
//   flush              : abort in-flight operation (no HI/LO update, no done)
//   busy               : high while not IDLE (pipeline stall)
//   done               : one-cycle pulse when new hi/lo are visible
//   hi, lo             : mult: product high/low; div: remainder/quotient
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide by zero skips RUN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit FAST_DIVZ = 1'b1;
`else
    localparam bit FAST_DIVZ = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             divz_q, divz_d;
    logic             neg_lo_q, neg_lo_d;   // product / quotient sign
    logic             neg_hi_q, neg_hi_d;   // remainder sign
    logic [WIDTH-1:0] b_q, b_d;             // |multiplier| or |divisor|
    logic [WIDTH-1:0] ph_q, ph_d;           // product high / partial remainder
    logic [WIDTH-1:0] pl_q, pl_d;           // multiplier bits / quotient bits
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Operand magnitudes at capture
    logic             a_neg, b_neg, req_div, req_ok, req_divz;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign a_neg    = op_signed & src_a[WIDTH-1];
    assign b_neg    = op_signed & src_b[WIDTH-1];
    assign req_div  = (alu_ctrl == ALU_DIV);
    assign req_ok   = (alu_ctrl == ALU_MULT) || req_div;
    assign req_divz = req_div && (src_b == '0);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.val(src_a), .neg(a_neg), .res(mag_a));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.val(src_b), .neg(b_neg), .res(mag_b));

    // One iteration of each algorithm
    logic [WIDTH:0] mul_sum, div_rem_s, div_diff;

    assign mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, b_q} : '0);
    assign div_rem_s = {ph_q, pl_q[WIDTH-1]};
    assign div_diff  = div_rem_s - {1'b0, b_q};

    // Sign correction of the finished magnitudes
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.val({ph_q, pl_q}), .neg(neg_lo_q), .res(prod_fix));
    muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_quo  (.val(pl_q), .neg(neg_lo_q), .res(quo_fix));
    muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_rem  (.val(ph_q), .neg(neg_hi_q), .res(rem_fix));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        divz_d   = divz_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_d      = b_q;
        ph_d     = ph_q;
        pl_d     = pl_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && req_ok && !flush) begin
                    is_div_d = req_div;
                    divz_d   = req_divz;
                    b_d      = mag_b;
                    cnt_d    = '0;
                    neg_hi_d = a_neg;
                    if (req_divz) begin
                        // Preload the final divide-by-zero answer and freeze it
                        // through RUN: remainder path rebuilds src_a from |a|
                        // with the dividend sign, quotient stays all ones.
                        neg_lo_d = 1'b0;
                        ph_d     = mag_a;
                        pl_d     = '1;
                        state_d  = FAST_DIVZ ? FIX : RUN;
                    end else begin
                        neg_lo_d = a_neg ^ b_neg;
                        ph_d     = '0;
                        pl_d     = mag_a;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (!divz_q) begin
                        if (is_div_q) begin
                            // Restoring step: keep the subtraction if it did not borrow
                            if (!div_diff[WIDTH]) begin
                                ph_d = div_diff[WIDTH-1:0];
                                pl_d = {pl_q[WIDTH-2:0], 1'b1};
                            end else begin
                                ph_d = div_rem_s[WIDTH-1:0];
                                pl_d = {pl_q[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            // Shift-add: conditional add into high half, shift pair right
                            ph_d = mul_sum[WIDTH:1];
                            pl_d = {mul_sum[0], pl_q[WIDTH-1:1]};
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_q      <= '0;
            ph_q     <= '0;
            pl_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            divz_q   <= divz_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_q      <= b_d;
            ph_q     <= ph_d;
            pl_q     <= pl_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (WIDTH=32). Issued
// operations push expected hi/lo and done cycle into a queue; a monitor pops
// and compares on every done pulse.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_DIVZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = W + 2;
`endif
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   alu_ctrl = 4'b0;
    logic         op_signed = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
        .op_signed(op_signed), .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] h;
        logic [W-1:0] l;
        int           c;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.h));
                chk("lo", 64'(lo), 64'(e.l));
                chk("done_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    // Start high for cycle 0 of the request; returns at negedge of cycle 1
    task automatic issue(input logic [3:0] c, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input int lat);
        exp_t e;
        @(negedge clk);
        alu_ctrl = c; op_signed = s; src_a = a; src_b = b; start = 1'b1;
        if (push) begin
            e.h = eh; e.l = el; e.c = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("idle_timeout", 64'd1, 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Signed 7 x -3 with busy profile over cycles 1..34
        issue(4'b0101, 1'b1, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, LAT);
        chk("busy_c1", 64'(busy), 64'd1);
        for (int k = 2; k <= LAT; k++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", k), 64'(busy), (k <= LAT - 1) ? 64'd1 : 64'd0);
        end
        wait_idle();

        // Back-to-back: second start lands exactly in the done cycle
        issue(4'b0101, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, LAT);
        repeat (LAT - 2) @(negedge clk);
        issue(4'b1011, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, LAT);
        wait_idle();

        issue(4'b1011, 1'b1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, LAT);
        wait_idle();
        issue(4'b1011, 1'b0, 32'd100, 32'd7, 1, 32'd2, 32'd14, LAT);
        wait_idle();
        issue(4'b1011, 1'b1, 32'h1234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, DZ_LAT);
        wait_idle();
        issue(4'b1011, 1'b1, 32'hFFFFFF00, 32'd0, 1, 32'hFFFFFF00, 32'hFFFFFFFF, DZ_LAT);
        wait_idle();

        // Flush in cycle 10 of a mult
        issue(4'b0101, 1'b0, 32'd5, 32'd6, 0, '0, '0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(dcnt), 64'd0);
        chk("flush_hi", 64'(hi), 64'hFFFFFF00);
        chk("flush_lo", 64'(lo), 64'hFFFFFFFF);

        // Invalid opcode is a no-op
        issue(4'b0010, 1'b0, 32'd1, 32'd1, 0, '0, '0, 0);
        chk("bad_op_busy", 64'(busy), 64'd0);

        // Flush in IDLE together with start drops the request
        @(negedge clk);
        alu_ctrl = 4'b0101; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", 64'(busy), 64'd0);

        // Start while busy is ignored
        issue(4'b0101, 1'b0, 32'd9, 32'd9, 1, 32'd0, 32'd81, LAT);
        repeat (3) @(negedge clk);
        alu_ctrl = 4'b1011; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in cycle 20 of a div
        issue(4'b1011, 1'b0, 32'd1000, 32'd3, 0, '0, '0, 0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        issue(4'b0101, 1'b1, 32'd3, 32'd4, 1, 32'd0, 32'd12, LAT);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
